// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the scanned 4-channel mux port.
// Optional build macro: MUX_SCAN_CONTINUOUS_EN (back-to-back sweeps).
package mux_scan_pkg;

  localparam int unsigned NCH   = 4;
  localparam int unsigned SEL_W = 2;

  typedef logic [1:0] stateT;

  localparam stateT StIdle   = 2'd0;
  localparam stateT StSettle = 2'd1;
  localparam stateT StSample = 2'd2;
  localparam stateT StDone   = 2'd3;

endpackage

// File: rtl/mux_scan_next.sv
// Finds the next enabled channel strictly above `cur`; cur = -1 yields the lowest
// enabled channel. `last` is high when no enabled channel lies above `cur`.
module mux_scan_next
  import mux_scan_pkg::*;
(
  input  logic [NCH-1:0]          mask,
  input  logic signed [SEL_W:0]   cur,
  output logic [SEL_W-1:0]        nxt,
  output logic                    last
);

  // Scan downward so the lowest qualifying channel is the one that sticks.
  always_comb begin
    nxt  = '0;
    last = 1'b1;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (mask[k] && (k > int'(cur))) begin
        nxt  = SEL_W'(k);
        last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sweep controller for MUX4x1: steps the select over enabled channels, settles,
// samples Y and publishes the captured word with a one-cycle valid pulse.
// Optional build macro: MUX_SCAN_CONTINUOUS_EN repeats sweeps until stop.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [NCH-1:0]     mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               Y,
  output logic [SEL_W-1:0]   S,
  output logic [NCH-1:0]     C,
  output logic               valid,
  output logic               busy
);

  stateT              stateQ, stateD;
  logic [SEL_W-1:0]   selQ, selD;
  logic [DWELL_W-1:0] cntQ, cntD;
  logic [DWELL_W-1:0] dwellQ, dwellD;
  logic [NCH-1:0]     maskQ, maskD;
  logic [NCH-1:0]     capQ, capD;
  logic [NCH-1:0]     cQ, cD;
  logic               validQ, validD;
  logic               busyQ, busyD;

  logic signed [SEL_W:0] lowCur, nextCur;
  logic [NCH-1:0]        lowMask;
  logic [SEL_W-1:0]      lowCh, nextCh;
  logic                  lowLast, nextLast;

  assign lowCur  = '1;
  assign nextCur = {1'b0, selQ};
  // Lowest-channel search uses the live mask only when launching from IDLE.
  assign lowMask = (stateQ == StIdle) ? mask : maskQ;

  mux_scan_next uLowest (
    .mask (lowMask),
    .cur  (lowCur),
    .nxt  (lowCh),
    .last (lowLast)
  );

  mux_scan_next uNext (
    .mask (maskQ),
    .cur  (nextCur),
    .nxt  (nextCh),
    .last (nextLast)
  );

  // Next-state and datapath decode; stop overrides everything outside IDLE.
  always_comb begin
    stateD = stateQ;
    selD   = selQ;
    cntD   = cntQ;
    dwellD = dwellQ;
    maskD  = maskQ;
    capD   = capQ;
    cD     = cQ;
    validD = 1'b0;
    case (stateQ)
      StIdle: begin
        if (start && !stop && !lowLast) begin
          maskD  = mask;
          dwellD = dwell;
          selD   = lowCh;
          cntD   = dwell;
          capD   = '0;
          stateD = StSettle;
        end
      end
      StSettle: begin
        if (cntQ != '0) begin
          cntD = cntQ - DWELL_W'(1);
        end else begin
          stateD = StSample;
        end
      end
      StSample: begin
        capD[selQ] = Y;
        if (!nextLast) begin
          selD   = nextCh;
          cntD   = dwellQ;
          stateD = StSettle;
        end else begin
          // Publish on the edge leaving the last sample so valid stays registered.
          cD     = capD;
          validD = 1'b1;
`ifdef MUX_SCAN_CONTINUOUS_EN
          // Restart straight into SETTLE so sweeps run back-to-back.
          selD   = lowCh;
          cntD   = dwellQ;
          capD   = '0;
          stateD = StSettle;
`else
          selD   = '0;
          stateD = StDone;
`endif
        end
      end
      StDone: begin
`ifdef MUX_SCAN_CONTINUOUS_EN
        selD   = lowCh;
        cntD   = dwellQ;
        capD   = '0;
        stateD = StSettle;
`else
        selD   = '0;
        stateD = StIdle;
`endif
      end
      default: begin
        selD   = '0;
        stateD = StIdle;
      end
    endcase
    if (stop && (stateQ != StIdle)) begin
      stateD = StIdle;
      selD   = '0;
      cD     = cQ;
      validD = 1'b0;
    end
    busyD = (stateD != StIdle);
  end

  // State and output registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= StIdle;
      selQ   <= '0;
      cntQ   <= '0;
      dwellQ <= '0;
      maskQ  <= '0;
      capQ   <= '0;
      cQ     <= '0;
      validQ <= 1'b0;
      busyQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      selQ   <= selD;
      cntQ   <= cntD;
      dwellQ <= dwellD;
      maskQ  <= maskD;
      capQ   <= capD;
      cQ     <= cD;
      validQ <= validD;
      busyQ  <= busyD;
    end
  end

  assign S     = selQ;
  assign C     = cQ;
  assign valid = validQ;
  assign busy  = busyQ;

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequential sweep controller that sits directly upstream of the 4:1 gate-level mux (`MUX4x1`). It drives the mux select `S`, waits a programmable settle time on each enabled channel, and samples the mux output `Y` back. At the end of a sweep it delivers the four captured bits as one parallel word. Together with the mux, it forms a scanned 4-channel input port.

## Interface
- `DWELL_W`, default 4: width of the settle-count input.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request a sweep; sampled only in IDLE.
- `stop`  in  1: abort the sweep in progress; sampled in every state.
- `mask`  in  4: channel enables, bit k = channel k; latched at start.
- `dwell`  in  DWELL_W: number of extra settle cycles per channel; latched at start.
- `Y`  in  1: mux output, fed back from `MUX4x1`.
- `S`  out  2: mux select, driven to `MUX4x1`.
- `C`  out  4: captured word; bit k holds `Y` sampled with `S`=k.
- `valid`  out  1: one-cycle pulse when `C` is updated.
- `busy`  out  1: high in every state except IDLE.

## Operation
- Reset values: state IDLE, `S`=00, `C`=0000, `valid`=0, `busy`=0, capture register 0, counter 0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- **IDLE**
  - `start`=1 and `mask`≠0: latch `mask` and `dwell`, set `S` to the lowest enabled channel, load the counter with `dwell`, clear the capture register, go to SETTLE.
  - `start`=1 and `mask`=0: ignored; remain in IDLE.
- **SETTLE**
  - Counter ≠0: decrement.
  - Counter =0: go to SAMPLE.
- **SAMPLE**
  - Capture register bit `S` ← `Y`.
  - If a higher enabled channel exists: set `S` to it, reload the counter with `dwell`, go to SETTLE.
  - Otherwise: go to DONE.
- **DONE**
  - `C` ← capture register, `valid`=1, `S` ← 00.
  - Next state is IDLE, or a restart (see Configuration).
- Masked channels are skipped entirely and their `C` bits are 0.
- `stop`=1 in any non-IDLE state: next state IDLE, `S` ← 00, no `valid`, `C` keeps its previous value. `stop` takes priority over every other transition, including DONE.
- `stop` and `start` high together in IDLE: stay in IDLE.
- `start` while busy: ignored.
- `mask` and `dwell` changes mid-sweep: no effect.
- Reset asserted mid-sweep: immediate return to the reset values; no `valid`.

## Timing
- Per enabled channel: `dwell`+2 cycles (`dwell`+1 in SETTLE, then 1 in SAMPLE).
- For n enabled channels, with edge 0 being the edge that samples `start`:
  - `valid` is high for exactly the cycle between edge n·(`dwell`+2) and edge n·(`dwell`+2)+1.
  - `busy` rises after edge 0 and falls after DONE.
- `S` changes only on the edge that enters SETTLE, so `Y` has had at least one full cycle to settle at `dwell`=0.
- `Y` is sampled with no synchronizer; it is combinational from registered `S`.
- All outputs are registered.

## Configuration
- `MUX_SCAN_CONTINUOUS_EN` defined: DONE returns to SETTLE on the lowest latched channel (counter reloaded, capture cleared) instead of IDLE. Sweeps repeat back-to-back and `valid` pulses once per sweep until `stop`. `busy` stays high between sweeps.
- Not defined: one-shot only; DONE always goes to IDLE.
- The port list is identical in both builds.

## Structure
- Package `mux_scan_pkg`:
  - State enum (IDLE, SETTLE, SAMPLE, DONE).
  - `NCH`=4 and `SEL_W`=2.
- Sub-module `mux_scan_next`: combinational. Given `mask` and the current channel, returns the next higher enabled channel plus a `last` flag. It is also used for the lowest-channel search with current = −1.

## Test plan
- `mask`=1111, `dwell`=0, mux `I`=1010, pulse `start` → `S` steps 0,1,2,3; `valid` at edge 8; `C`=1010; `busy` low next cycle.
- `mask`=0101, `dwell`=3, `I`=0111 → `S` visits only 0 and 2, each held 5 cycles; `valid` at edge 10; `C`=0101.
- `mask`=0000 with `start` → stays IDLE; `busy`, `valid` and `S` stay 0.
- Sweep with `mask`=1111, `dwell`=2, `stop` at edge 6 → IDLE at edge 7; `S`=00; no `valid`; `C` unchanged from the prior sweep.
- `rst` asserted asynchronously mid-SETTLE → all outputs at reset values before the next clock edge; a subsequent `start` runs normally.
- Continuous build, `mask`=1000, `dwell`=1, `I` toggling bit 3 between sweeps → `valid` every 3 cycles; `C` tracks bit 3; `stop` ends it.
